// File: rtl/ram_arb2.sv
// Two-master round-robin arbiter with bounded bursts for a 128x4 single-port RAM.
// Optional per-master grant counters (gcnt0/gcnt1) are enabled with `define RAM_ARB2_STATS_EN.
module ram_arb2 #(
  parameter int AW        = 7,
  parameter int DW        = 4,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef RAM_ARB2_STATS_EN
  ,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1
`endif
);

  localparam logic [3:0] BM = 4'(BURST_MAX);

  logic          r_owner;
  logic [3:0]    r_cnt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_win;
  logic          w_rd;

  // Contention goes to the owner until its burst is used up; reset blocks all grants.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_win  = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        w_win  = (r_cnt >= BM) ? ~r_owner : r_owner;
        w_gnt0 = ~w_win;
        w_gnt1 = w_win;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign w_rd      = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);
  assign ack0      = w_gnt0;
  assign ack1      = w_gnt1;
  assign ram_enb   = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign ram_addr  = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);
  assign ram_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= 1'b0;
      r_cnt     <= 4'd0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (w_rd)
        r_rdata <= ram_rdata;
      if (w_gnt0 || w_gnt1) begin
        if (w_gnt1 == r_owner) begin
          if (r_cnt < BM)
            r_cnt <= r_cnt + 4'd1;
        end else begin
          r_owner <= w_gnt1;
          r_cnt   <= 4'd1;
        end
      end
    end
  end

`ifdef RAM_ARB2_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gcnt0 <= 16'd0;
      r_gcnt1 <= 16'd0;
    end else begin
      if (w_gnt0)
        r_gcnt0 <= r_gcnt0 + 16'd1;
      if (w_gnt1)
        r_gcnt1 <= r_gcnt1 + 16'd1;
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
`endif

endmodule

// File: tb/tb_ram_arb2.sv
// Self-checking bench for ram_arb2: vector table with hand-derived acks, read-data scoreboard.
// Grant counters are checked too when RAM_ARB2_STATS_EN is defined.
module tb_ram_arb2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [6:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [3:0] rdata;
  logic       ram_enb;
  logic [6:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
`ifdef RAM_ARB2_STATS_EN
  logic [15:0] gcnt0, gcnt1;
`endif

  ram_arb2 #(.AW(7), .DW(4), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_enb(ram_enb), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_ARB2_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on the rising edge when enabled, combinational read.
  logic [3:0] mem [128];
  always @(posedge clk) if (ram_enb) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    logic       rst, r0, r1, w0, w1;
    logic [6:0] a0, a1;
    logic [3:0] d0, d1;
    logic       ea0, ea1;
  } vec_t;

  typedef struct {
    logic       rv0, rv1;
    logic [3:0] data;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbQ[$];
  logic [3:0] shadow [128];
  logic [3:0] expRdata;
  int         checks   = 0;
  int         failures = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic rs, input logic r0, input logic r1, input logic w0,
                        input logic w1, input logic [6:0] a0, input logic [6:0] a1,
                        input logic [3:0] d0, input logic [3:0] d1,
                        input logic ea0, input logic ea1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.ea0 = ea0; v.ea1 = ea1;
    vecs.push_back(v);
  endtask

  // One cycle: check last cycle's read result, drive inputs, check combinational grant.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(negedge clk);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("rvalid0", int'(rvalid0), int'(e.rv0));
      checkOutput("rvalid1", int'(rvalid1), int'(e.rv1));
      if (e.rv0 || e.rv1) expRdata = e.data;
      checkOutput("rdata", int'(rdata), int'(expRdata));
    end
    rst = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    #1;
    if (!v.rst) begin
      expRdata = 4'h0;
      checkOutput("rst_rvalid", int'(rvalid0 | rvalid1), 0);
      checkOutput("rst_rdata", int'(rdata), 0);
    end
    checkOutput("ack0", int'(ack0), int'(v.ea0));
    checkOutput("ack1", int'(ack1), int'(v.ea1));
    checkOutput("ram_enb", int'(ram_enb), int'((v.ea0 & v.w0) | (v.ea1 & v.w1)));
    checkOutput("ram_addr", int'(ram_addr), v.ea0 ? int'(v.a0) : (v.ea1 ? int'(v.a1) : 0));
    checkOutput("ram_wdata", int'(ram_wdata), v.ea0 ? int'(v.d0) : (v.ea1 ? int'(v.d1) : 0));
    e.rv0 = 1'b0; e.rv1 = 1'b0; e.data = 4'h0;
    if (v.ea0 && !v.w0) begin e.rv0 = 1'b1; e.data = shadow[v.a0]; end
    if (v.ea1 && !v.w1) begin e.rv1 = 1'b1; e.data = shadow[v.a1]; end
    if (v.ea0 && v.w0) shadow[v.a0] = v.d0;
    if (v.ea1 && v.w1) shadow[v.a1] = v.d1;
    sbQ.push_back(e);
  endtask

  initial begin
    sb_t e0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 4'h0;
      shadow[i] = 4'h0;
    end
    expRdata = 4'h0;

    // Write 0x05=A then read it back.
    addVec(1, 1, 0, 1, 0, 7'h05, 7'h00, 4'hA, 4'h0, 1, 0);
    addVec(1, 1, 0, 0, 0, 7'h05, 7'h00, 4'h0, 4'h0, 1, 0);
    addVec(1, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);
    // Reset, then both masters read continuously: bursts of four.
    addVec(0, 1, 1, 0, 0, 7'h05, 7'h06, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 10; i++)
      addVec(1, 1, 1, 0, 0, 7'h05, 7'h06, 4'h0, 4'h0, (i < 4 || i >= 8), (i >= 4 && i < 8));
    addVec(1, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);
    // Master 1 alone writes ten words, master 0 sweeps them back.
    for (int i = 0; i < 10; i++)
      addVec(1, 0, 1, 0, 1, 7'h00, 7'(i), 4'h0, 4'(i), 0, 1);
    for (int i = 0; i < 10; i++)
      addVec(1, 1, 0, 0, 0, 7'(i), 7'h00, 4'h0, 4'h0, 1, 0);
    // Make master 0 owner with a fresh burst, then contend on 0x7F.
    addVec(1, 0, 1, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 1);
    addVec(1, 1, 0, 0, 0, 7'h01, 7'h00, 4'h0, 4'h0, 1, 0);
    addVec(1, 1, 1, 1, 0, 7'h7F, 7'h7F, 4'h3, 4'h0, 1, 0);
    addVec(1, 0, 1, 0, 0, 7'h00, 7'h7F, 4'h0, 4'h0, 0, 1);
    addVec(1, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);
    // Reset during a read request, then master 0 wins first after release.
    addVec(1, 1, 0, 0, 0, 7'h05, 7'h00, 4'h0, 4'h0, 1, 0);
    addVec(0, 1, 0, 0, 0, 7'h05, 7'h00, 4'h0, 4'h0, 0, 0);
    addVec(1, 1, 1, 0, 0, 7'h05, 7'h7F, 4'h0, 4'h0, 1, 0);
    addVec(1, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);
    // Reset, five solo grants to master 0, three to master 1.
    addVec(0, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec(1, 1, 0, 0, 0, 7'(i), 7'h00, 4'h0, 4'h0, 1, 0);
    for (int i = 0; i < 3; i++)
      addVec(1, 0, 1, 1, 1, 7'h00, 7'(20 + i), 4'h0, 4'(i + 5), 0, 1);
    addVec(1, 0, 0, 0, 0, 7'h00, 7'h00, 4'h0, 4'h0, 0, 0);

    // Hold reset with both masters requesting: nothing may be granted.
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 7'h11; addr1 = 7'h22; wdata0 = 4'h5; wdata1 = 4'h6;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ack0", int'(ack0), 0);
    checkOutput("reset_ack1", int'(ack1), 0);
    checkOutput("reset_ram_enb", int'(ram_enb), 0);
    checkOutput("reset_ram_addr", int'(ram_addr), 0);
    checkOutput("reset_ram_wdata", int'(ram_wdata), 0);
    checkOutput("reset_rvalid", int'(rvalid0 | rvalid1), 0);
    checkOutput("reset_rdata", int'(rdata), 0);
`ifdef RAM_ARB2_STATS_EN
    checkOutput("reset_gcnt0", int'(gcnt0), 0);
    checkOutput("reset_gcnt1", int'(gcnt1), 0);
`endif
    e0.rv0 = 1'b0; e0.rv1 = 1'b0; e0.data = 4'h0;
    sbQ.push_back(e0);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i]);

`ifdef RAM_ARB2_STATS_EN
    checkOutput("gcnt0", int'(gcnt0), 5);
    checkOutput("gcnt1", int'(gcnt1), 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("gcnt0_after_reset", int'(gcnt0), 0);
    checkOutput("gcnt1_after_reset", int'(gcnt1), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arb2.md
# ram_arb2

Two-requester arbiter and sequencer for the 128x4 single-port RAM (write-enable high = write, low = combinational read, async active-low reset). It lets two independent masters share the one RAM port, granting at most one access per cycle. The scheme is round-robin with a bounded burst: a master may keep the port for up to BURST_MAX back-to-back accesses while the other waits. It sits between the masters and the RAM instance, and is the only driver of the RAM's enb/addr/w_data.

## Interface
- AW, 7, RAM address width (128 words)
- DW, 4, RAM data width
- BURST_MAX, 4, max consecutive grants to one master while the other requests (legal 1..15)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  AW  word address; stable while req high
- wdata0 / wdata1  in  DW  write data; stable while req high
- ack0 / ack1  out  1  combinational; access issued this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid (one cycle)
- rdata  out  DW  registered read data, shared by both masters
- ram_enb  out  1  to RAM enb
- ram_addr  out  AW  to RAM addr
- ram_wdata  out  DW  to RAM w_data
- ram_rdata  in  DW  from RAM r_data (combinational)

## Operation
- State:
  - owner (1 bit): last granted master.
  - cnt (4 bits): consecutive grants to owner.
  - rdata, rvalid0, rvalid1.
- Grant decision, combinational every cycle:
  - Neither req: no grant.
  - One req: grant it.
  - Both req, cnt < BURST_MAX: grant owner.
  - Both req, cnt == BURST_MAX: grant the other master.
- Granted master i:
  - ack_i = 1.
  - ram_addr = addr_i.
  - ram_wdata = wdata_i.
  - ram_enb = we_i.
- No grant:
  - ram_enb = 0.
  - ram_addr = 0.
  - ram_wdata = 0.
  - Idle cycles are harmless reads.
- Update on each grant:
  - Same master as owner: cnt <= min(cnt+1, BURST_MAX).
  - Different master: owner <= winner, cnt <= 1.
  - No grant: owner and cnt hold.
- Granted read: rdata <= ram_rdata and rvalid_i <= 1 at the next edge. Otherwise rvalid0/1 <= 0 and rdata holds.
- Never both ack0 and ack1 in the same cycle; never ram_enb=1 without an ack.

## Timing
- A request is issued in the cycle its ack is high.
  - The master may change or drop req/we/addr/wdata after that clock edge.
  - A new request may be presented in the next cycle.
- Latency:
  - Write: completes in the RAM at the edge ending the ack cycle.
  - Read: data and rvalid appear one cycle after ack.
- Throughput:
  - 1 access per cycle total.
  - Single requester: back-to-back acks every cycle; cnt saturates and no switch occurs.
- Read-after-write, same address, consecutive grants (either master): the read returns the new data.
- Reset values:
  - owner=0, cnt=0.
  - rvalid0=rvalid1=0, rdata=0.
  - While rst low: ack0=ack1=0, ram_enb=0, ram_addr=0, ram_wdata=0.
- Both req in the first cycle after reset: master 0 wins (owner=0, cnt=0<BURST_MAX).
- Reset mid-operation: in-flight rvalid is cleared and no write is issued. Masters must re-request.
- A req deasserted without ack is a protocol violation. Behaviour is undefined and no check is made.

## Configuration
- RAM_ARB2_STATS_EN:
  - Defined: adds outputs gcnt0 and gcnt1, 16 bits each. Each counts acks for its master, wraps at 0xFFFF→0, and resets to 0.
  - Undefined: ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset, then master 0 writes addr 0x05 data 0xA. One cycle later master 0 reads 0x05 -> ack0 in each request cycle; rvalid0=1 and rdata=0xA one cycle after the read ack.
- req0 and req1 both held continuously with BURST_MAX=4, all reads -> ack pattern 0,0,0,0,1,1,1,1,0,... Never both acks in one cycle.
- Master 1 alone issues 10 back-to-back writes to 0x00..0x09 (data = addr[3:0]) -> ack1 high for 10 cycles; a subsequent read sweep returns 0x0..0x9.
- Master 0 writes 0x7F=0x3 while master 1 waits with a read of 0x7F. Master 1 is granted next -> rdata=0x3 with rvalid1 one cycle after ack1.
- rst pulled low during a read ack cycle -> rvalid stays 0, ram_enb=0, all outputs at reset values. After release, both req -> master 0 granted first.
- With RAM_ARB2_STATS_EN: 5 grants to master 0 and 3 grants to master 1 -> gcnt0=5, gcnt1=3. After reset both read 0.
